// File: rtl/phase_seq_pkg.sv
// Shared types and boot constants for the phase sequencer.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_HELLO,
    ST_SIZE,
    ST_PROG,
    ST_ACK,
    ST_RUN,
    ST_HALT
  } state_e;

  typedef enum logic {
    SLOT_COMPUTE,
    SLOT_LATCH
  } slot_e;

  localparam logic [7:0] BOOT_BYTE_HELLO = 8'h99;
  localparam logic [7:0] BOOT_BYTE_ACK   = 8'hAA;
  localparam logic [7:0] BOOT_BYTE_NONE  = 8'h00;

  // Byte the host link should emit while the sequencer sits in a given state.
  function automatic logic [7:0] boot_byte(input state_e st);
    case (st)
      ST_HELLO: return BOOT_BYTE_HELLO;
      ST_ACK:   return BOOT_BYTE_ACK;
      default:  return BOOT_BYTE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/phase_seq_perf.sv
// Performance counters: RUN cycles and retired instructions, wrapping at 2^CNT_W.
module phase_seq_perf #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run_active,
  input  logic             instr_done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (run_active) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (instr_done) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Boot handshake plus per-stage COMPUTE/LATCH sequencing of a multi-stage core.
// Optional counters (cycle_cnt, instret_cnt) enabled by defining PHASE_SEQ_PERF_EN.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  halt_req,
  input  logic                  size_fetch_done,
  input  logic                  prog_fetch_done,
  output logic                  tx_req_99,
  output logic                  size_wren,
  output logic                  prog_wren,
  output logic                  tx_req_aa,
  output logic [NUM_STAGES-1:0] stage_act,
  output logic [NUM_STAGES-1:0] latch_wren,
  output logic                  pc_wren,
  output logic                  instr_done,
  output logic                  halted
`ifdef PHASE_SEQ_PERF_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
`endif
);

  localparam int unsigned STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 16 || CNT_W < 1) begin : g_param_check
    $error("phase_sequencer: parameter out of range");
  end

  state_e               state_q, state_d;
  slot_e                slot_q, slot_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 halt_pend_q, halt_pend_d;
  logic [NUM_STAGES-1:0] stage_onehot;

  assign stage_onehot = NUM_STAGES'(1) << stage_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      slot_q      <= SLOT_COMPUTE;
      stage_q     <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      stage_q     <= stage_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  // Next state; a pending halt is honoured only at the instruction wrap.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    stage_d     = stage_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      ST_INIT:  state_d = ST_HELLO;
      ST_HELLO: state_d = ST_SIZE;
      ST_SIZE:  if (size_fetch_done) state_d = ST_PROG;
      ST_PROG:  if (prog_fetch_done) state_d = ST_ACK;
      ST_ACK: begin
        state_d = ST_RUN;
        stage_d = '0;
        slot_d  = SLOT_COMPUTE;
      end
      ST_RUN: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (!stall) begin
          if (slot_q == SLOT_COMPUTE) begin
            slot_d = SLOT_LATCH;
          end else begin
            slot_d = SLOT_COMPUTE;
            if (stage_q == LAST_STAGE) begin
              stage_d = '0;
              if (halt_pend_q || halt_req) state_d = ST_HALT;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_INIT;
    endcase
  end

  // Outputs; an asserted reset_n-low cycle suppresses every enable immediately.
  always_comb begin
    tx_req_99  = 1'b0;
    size_wren  = 1'b0;
    prog_wren  = 1'b0;
    tx_req_aa  = 1'b0;
    stage_act  = '0;
    latch_wren = '0;
    pc_wren    = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    if (reset_n) begin
      tx_req_99 = (boot_byte(state_q) == BOOT_BYTE_HELLO);
      tx_req_aa = (boot_byte(state_q) == BOOT_BYTE_ACK);
      size_wren = (state_q == ST_SIZE);
      prog_wren = (state_q == ST_PROG);
      halted    = (state_q == ST_HALT);
      if (state_q == ST_RUN) begin
        stage_act = stage_onehot;
        if (slot_q == SLOT_LATCH && !stall) begin
          latch_wren = stage_onehot;
          if (stage_q == LAST_STAGE) begin
            pc_wren    = 1'b1;
            instr_done = 1'b1;
          end
        end
      end
    end
  end

`ifdef PHASE_SEQ_PERF_EN
  phase_seq_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset_n     (reset_n),
    .run_active  (state_q == ST_RUN),
    .instr_done  (instr_done),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer against a phase-count reference model.
module tb_phase_sequencer;

  localparam int unsigned N  = 5;
  localparam int unsigned CW = 4;
  localparam int unsigned OW = 2 * N + 7;

  localparam int M_INIT = 0, M_HELLO = 1, M_SIZE = 2, M_PROG = 3,
                 M_ACK = 4, M_RUN = 5, M_HALT = 6;

  logic clk, reset_n, stall, halt_req, size_fetch_done, prog_fetch_done;
  logic tx_req_99, size_wren, prog_wren, tx_req_aa, pc_wren, instr_done, halted;
  logic [N-1:0] stage_act, latch_wren;
`ifdef PHASE_SEQ_PERF_EN
  logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

  phase_sequencer #(.NUM_STAGES(N), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .halt_req        (halt_req),
    .size_fetch_done (size_fetch_done),
    .prog_fetch_done (prog_fetch_done),
    .tx_req_99       (tx_req_99),
    .size_wren       (size_wren),
    .prog_wren       (prog_wren),
    .tx_req_aa       (tx_req_aa),
    .stage_act       (stage_act),
    .latch_wren      (latch_wren),
    .pc_wren         (pc_wren),
    .instr_done      (instr_done),
    .halted          (halted)
`ifdef PHASE_SEQ_PERF_EN
    ,
    .cycle_cnt       (cycle_cnt),
    .instret_cnt     (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] outs;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: mode, phase index within the instruction (0..2N-1), sticky halt.
  int m_mode, m_phase, m_cyc, m_ret, m_ret_total;
  bit m_hp;
  bit stim_done;

  function automatic logic [OW-1:0] expect_out(input bit r, input bit st);
    logic [N-1:0] one, sa, lw;
    bit tx99, sw, pw, txaa, pc, dn, hl;
    one = 1;
    sa = '0; lw = '0;
    tx99 = 0; sw = 0; pw = 0; txaa = 0; pc = 0; dn = 0; hl = 0;
    if (r) begin
      case (m_mode)
        M_HELLO: tx99 = 1;
        M_SIZE:  sw = 1;
        M_PROG:  pw = 1;
        M_ACK:   txaa = 1;
        M_HALT:  hl = 1;
        M_RUN: begin
          sa = one << (m_phase / 2);
          if (m_phase % 2 == 1 && !st) begin
            lw = sa;
            if (m_phase == 2 * N - 1) begin pc = 1; dn = 1; end
          end
        end
        default: ;
      endcase
    end
    return {tx99, sw, pw, txaa, sa, lw, pc, dn, hl};
  endfunction

  task automatic model_step(input bit r, input bit st, input bit hr,
                            input bit sfd, input bit pfd);
    bit done;
    if (!r) begin
      m_mode = M_INIT; m_phase = 0; m_hp = 0; m_cyc = 0; m_ret = 0;
      return;
    end
    done = (m_mode == M_RUN) && (m_phase == 2 * N - 1) && !st;
    if (m_mode == M_RUN) m_cyc++;
    if (done) begin m_ret++; m_ret_total++; end
    case (m_mode)
      M_INIT:  m_mode = M_HELLO;
      M_HELLO: m_mode = M_SIZE;
      M_SIZE:  if (sfd) m_mode = M_PROG;
      M_PROG:  if (pfd) m_mode = M_ACK;
      M_ACK:   begin m_mode = M_RUN; m_phase = 0; end
      M_RUN: begin
        if (hr) m_hp = 1;
        if (!st) begin
          if (m_phase == 2 * N - 1) begin
            m_phase = 0;
            if (m_hp) m_mode = M_HALT;
          end else begin
            m_phase++;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input bit r, input bit st, input bit hr,
                      input bit sfd, input bit pfd);
    exp_t e;
    reset_n = r; stall = st; halt_req = hr;
    size_fetch_done = sfd; prog_fetch_done = pfd;
    e.outs = expect_out(r, st);
    e.cyc  = CW'(m_cyc);
    e.ret  = CW'(m_ret);
    exp_q.push_back(e);
    @(posedge clk);
    model_step(r, st, hr, sfd, pfd);
    #1;
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 4 * N && !(m_mode == M_RUN && m_phase == ph); i++)
      step(1, 0, 0, 0, 0);
  endtask

  task automatic rand_boot();
    for (int i = 0; i < 200 && m_mode != M_RUN; i++)
      step(1, $urandom_range(1) == 0, $urandom_range(1) == 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0);
  endtask

  task automatic rand_step(input int halt_div);
    step($urandom_range(99) != 0, $urandom_range(3) == 0,
         $urandom_range(halt_div - 1) == 0,
         $urandom_range(3) == 0, $urandom_range(3) == 0);
  endtask

  initial begin
    reset_n = 0; stall = 0; halt_req = 0;
    size_fetch_done = 0; prog_fetch_done = 0;
    m_mode = M_INIT; m_phase = 0; m_hp = 0;
    m_cyc = 0; m_ret = 0; m_ret_total = 0; stim_done = 0;
    @(posedge clk); #1;

    // Directed boot: size done at cycle 5, program done at cycle 10, then 3 instructions
    step(0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) step(1, 0, 0, c == 5, c == 10);
    repeat (30) step(1, 0, 0, 0, 0);

    // Four-cycle stall on the LATCH slot of stage 2
    run_to_phase(5);
    repeat (4) step(1, 1, 0, 0, 0);
    run_to_phase(0);

    repeat (300) step(1, $urandom_range(3) == 0, 0, 0, 0);

    // Halt requested during COMPUTE of stage 1
    run_to_phase(2);
    step(1, 0, 1, 0, 0);
    repeat (30) step(1, 0, 0, 0, 0);
    repeat (10) step(1, $urandom_range(1) == 0, $urandom_range(1) == 0, 0, 0);

    // Reset on the LATCH slot of stage 3 aborts the instruction and reboots
    step(0, 0, 0, 0, 0);
    rand_boot();
    run_to_phase(7);
    step(0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);

    // Halt together with the final LATCH slot
    rand_boot();
    run_to_phase(2 * N - 1);
    step(1, 0, 1, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0);

    repeat (6) begin
      step(0, 0, 0, 0, 0);
      rand_boot();
      repeat (150) rand_step(40);
    end
    stim_done = 1;
  end

  int n_tests, n_fail, mon_cycles, done_seen;
  bit halt_seen;
  exp_t mon_e;
  logic [OW-1:0] act;

  initial begin
    n_tests = 0; n_fail = 0; mon_cycles = 0; done_seen = 0; halt_seen = 0;
  end

  // Monitor: pops one expectation per presented output cycle, then closes out.
  always @(negedge clk) begin
    mon_cycles++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      act = {tx_req_99, size_wren, prog_wren, tx_req_aa, stage_act, latch_wren,
             pc_wren, instr_done, halted};
      if (instr_done === 1'b1) done_seen++;
      if (halted === 1'b1) halt_seen = 1;
      n_tests++;
      if (act !== mon_e.outs) begin
        n_fail++;
        $display("FAIL outputs t=%0t got=%b exp=%b", $time, act, mon_e.outs);
      end
`ifdef PHASE_SEQ_PERF_EN
      n_tests++;
      if (cycle_cnt !== mon_e.cyc || instret_cnt !== mon_e.ret) begin
        n_fail++;
        $display("FAIL perf_cnt t=%0t got cyc=%0d ret=%0d exp cyc=%0d ret=%0d",
                 $time, cycle_cnt, instret_cnt, mon_e.cyc, mon_e.ret);
      end
`endif
    end else if (stim_done) begin
      n_tests++;
      if (done_seen != m_ret_total) begin
        n_fail++;
        $display("FAIL retire_count got=%0d exp=%0d", done_seen, m_ret_total);
      end
      n_tests++;
      if (!halt_seen) begin
        n_fail++;
        $display("FAIL halt_observed got=0 exp=1");
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    if (mon_cycles > 20000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout cycles=%0d limit=20000", mon_cycles);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

endmodule
